// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage
//  Description : Issue stage in front of the combinational ALU. Holds the
//                register file and a per-register pending scoreboard, reads
//                operands with write-back bypass, and presents one registered
//                {a, b, op, rd} bundle over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_stage #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  parameter int OP_W   = 3,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [OP_W-1:0]   i_in_op,
  input  logic [AW-1:0]     i_in_rd,
  input  logic [AW-1:0]     i_in_rs1,
  input  logic [AW-1:0]     i_in_rs2,
  input  logic              i_in_use_imm,
  input  logic [DATA_W-1:0] i_in_imm,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [OP_W-1:0]   o_op,
  output logic [AW-1:0]     o_rd,
  input  logic              i_wb_en,
  input  logic [AW-1:0]     i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_v
);

  logic [DATA_W-1:0] regs [REG_N];
  logic [REG_N-1:0]  pending;

  logic              out_valid;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [AW-1:0]     rd_q;

  logic              wb_write;
  logic              rs1_byp;
  logic              rs2_byp;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              hazard;
  logic              in_ready;
  logic              accept;

  // r0 is hard-wired to zero, so a write-back addressed to it is dropped.
  assign wb_write = i_wb_en && (i_wb_rd != '0);

  // Operand fetch with bypass from the write-back port, plus the scoreboard
  // hazard check. A source that is being written this very cycle is not a
  // hazard: the bypassed value is used instead.
  always_comb begin
    rs1_byp = i_wb_en && (i_wb_rd == i_in_rs1);
    rs2_byp = i_wb_en && (i_wb_rd == i_in_rs2);

    if (i_in_rs1 == '0)  rs1_val = '0;
    else if (rs1_byp)    rs1_val = i_wb_v;
    else                 rs1_val = regs[i_in_rs1];

    if (i_in_rs2 == '0)  rs2_val = '0;
    else if (rs2_byp)    rs2_val = i_wb_v;
    else                 rs2_val = regs[i_in_rs2];

    hazard = (pending[i_in_rs1] && !rs1_byp) ||
             (!i_in_use_imm && pending[i_in_rs2] && !rs2_byp);
  end

  // Ready depends only on output occupancy and source hazards, never on
  // i_in_valid, so upstream may present fields and wait for ready.
  assign in_ready = (!out_valid || i_out_ready) && !hazard;
  assign accept   = i_in_valid && in_ready;

  // Register file and scoreboard. The accept-side set is written after the
  // write-back clear so that set wins when both hit the same register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (wb_write) begin
        regs[i_wb_rd]    <= i_wb_v;
        pending[i_wb_rd] <= 1'b0;
      end
      if (accept && (i_in_rd != '0)) begin
        pending[i_in_rd] <= 1'b1;
      end
    end
  end

  // Output bundle register: load on accept, drop valid when drained, hold
  // everything while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a_q       <= rs1_val;
      b_q       <= i_in_use_imm ? i_in_imm : rs2_val;
      op_q      <= i_in_op;
      rd_q      <= i_in_rd;
    end else if (i_out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = in_ready;
  assign o_out_valid = out_valid;
  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_op        = op_q;
  assign o_rd        = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_stage
//  Description : Self-checking bench for operand_stage: directed scenarios
//                plus a randomized run against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_rs1;
  logic [2:0] in_rs2;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic [2:0] rd;
  logic       wb_en;
  logic [2:0] wb_rd;
  logic [7:0] wb_v;

  int n_cmp = 0;
  int n_err = 0;

  operand_stage #(.DATA_W(8), .REG_N(8), .OP_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_op(in_op), .i_in_rd(in_rd), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2),
    .i_in_use_imm(in_use_imm), .i_in_imm(in_imm),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_a(a), .o_b(b), .o_op(op), .o_rd(rd),
    .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_v(wb_v)
  );

  always #5 clk = ~clk;

  // Behavioural reference: architectural registers, set of in-flight
  // destinations, and the bundle the consumer should currently see.
  logic [7:0] m_reg  [8];
  bit         m_pend [8];
  bit         m_valid;
  logic [7:0] m_a, m_b;
  logic [2:0] m_op, m_rd;
  bit         exp_ready;
  logic       obs_ready;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = 8'h00;
      m_pend[i] = 1'b0;
    end
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
  endtask

  function automatic logic [7:0] m_src(input logic [2:0] r);
    if (r == 0) return 8'h00;
    if (wb_en && wb_rd == r) return wb_v;
    return m_reg[r];
  endfunction

  function automatic bit m_blocked(input logic [2:0] r);
    return m_pend[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = m_blocked(in_rs1) || (!in_use_imm && m_blocked(in_rs2));
    return (!m_valid || out_ready) && !haz;
  endfunction

  task automatic idle();
    in_valid = 0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_use_imm = 0; in_imm = 0; out_ready = 1;
    wb_en = 0; wb_rd = 0; wb_v = 0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] d,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input logic ui, input logic [7:0] im);
    in_valid = 1; in_op = o; in_rd = d; in_rs1 = s1; in_rs2 = s2;
    in_use_imm = ui; in_imm = im;
  endtask

  task automatic writeback(input logic [2:0] r, input logic [7:0] v);
    wb_en = 1; wb_rd = r; wb_v = v;
  endtask

  // One clock: sample ready mid-cycle, advance the model, step past the edge.
  task automatic cycle();
    logic [7:0] na, nb;
    bit acc;
    #2;
    exp_ready = m_ready();
    obs_ready = in_ready;
    acc = in_valid && exp_ready;
    na  = m_src(in_rs1);
    nb  = in_use_imm ? in_imm : m_src(in_rs2);
    if (wb_en && wb_rd != 0) begin
      m_reg[wb_rd]  = wb_v;
      m_pend[wb_rd] = 1'b0;
    end
    if (acc) begin
      m_valid = 1; m_a = na; m_b = nb; m_op = in_op; m_rd = in_rd;
      if (in_rd != 0) m_pend[in_rd] = 1'b1;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    #3;
    n_cmp++;
    if ({out_valid, a, b, op, rd} !== 23'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b a=%h b=%h op=%h rd=%h, want all 0",
               out_valid, a, b, op, rd);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    cycle();
    n_cmp++;
    if (obs_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", obs_ready);
    end
  endtask

  task automatic test_basic();
    idle(); writeback(3'd1, 8'h05); cycle();
    idle(); writeback(3'd2, 8'h03); cycle();
    idle(); issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00); cycle();
    n_cmp++;
    if ({out_valid, a, b, op, rd} !== {1'b1, 8'h05, 8'h03, 3'd0, 3'd3}) begin
      n_err++;
      $display("FAIL basic_issue: got v=%0b a=%h b=%h op=%h rd=%h, want 1 05 03 0 3",
               out_valid, a, b, op, rd);
    end
    idle(); writeback(3'd3, 8'h08); cycle();
  endtask

  task automatic test_imm_r0();
    idle(); issue(3'd2, 3'd0, 3'd0, 3'd6, 1'b1, 8'hF0); cycle();
    n_cmp++;
    if ({out_valid, a, b, op, rd} !== {1'b1, 8'h00, 8'hF0, 3'd2, 3'd0}) begin
      n_err++;
      $display("FAIL imm_issue: got v=%0b a=%h b=%h op=%h rd=%h, want 1 00 F0 2 0",
               out_valid, a, b, op, rd);
    end
    // r0 must never become pending: an immediate reader of r0 issues at once.
    idle(); issue(3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00); cycle();
    n_cmp++;
    if (obs_ready !== 1'b1) begin
      n_err++;
      $display("FAIL r0_not_pending: ready got %b want 1", obs_ready);
    end
    idle(); cycle();
  endtask

  task automatic test_stall_bypass();
    idle(); issue(3'd1, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00); cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); issue(3'd3, 3'd6, 3'd4, 3'd0, 1'b0, 8'h00); cycle();
      n_cmp++;
      if (obs_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_ready[%0d]: got %b want 0", k, obs_ready);
      end
    end
    idle(); issue(3'd3, 3'd6, 3'd4, 3'd0, 1'b0, 8'h00); writeback(3'd4, 8'hAA); cycle();
    n_cmp++;
    if (obs_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_ready: got %b want 1", obs_ready);
    end
    n_cmp++;
    if ({out_valid, a, rd} !== {1'b1, 8'hAA, 3'd6}) begin
      n_err++;
      $display("FAIL bypass_value: got v=%0b a=%h rd=%h, want 1 AA 6", out_valid, a, rd);
    end
    idle(); writeback(3'd6, 8'h11); cycle();
  endtask

  task automatic test_backpressure();
    logic [22:0] held;
    idle(); issue(3'd5, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00); cycle();
    held = {out_valid, a, b, op, rd};
    for (int k = 0; k < 3; k++) begin
      idle(); out_ready = 0; issue(3'd6, 3'd0, 3'd1, 3'd0, 1'b1, 8'h5A); cycle();
      n_cmp++;
      if (obs_ready !== 1'b0 || {out_valid, a, b, op, rd} !== held) begin
        n_err++;
        $display("FAIL hold[%0d]: ready=%b bundle=%h, want ready 0 bundle %h",
                 k, obs_ready, {out_valid, a, b, op, rd}, held);
      end
    end
    idle(); out_ready = 1; issue(3'd6, 3'd0, 3'd1, 3'd0, 1'b1, 8'h5A); cycle();
    n_cmp++;
    if (obs_ready !== 1'b1 ||
        {out_valid, a, b, op, rd} !== {1'b1, 8'h05, 8'h5A, 3'd6, 3'd0}) begin
      n_err++;
      $display("FAIL replace: ready=%b v=%0b a=%h b=%h op=%h rd=%h, want 1 1 05 5A 6 0",
               obs_ready, out_valid, a, b, op, rd);
    end
    idle(); writeback(3'd7, 8'h22); cycle();
  endtask

  task automatic test_set_wins();
    idle(); issue(3'd0, 3'd5, 3'd0, 3'd0, 1'b0, 8'h00); writeback(3'd5, 8'h77); cycle();
    idle(); issue(3'd0, 3'd1, 3'd5, 3'd0, 1'b1, 8'h00); cycle();
    n_cmp++;
    if (obs_ready !== 1'b0) begin
      n_err++;
      $display("FAIL set_wins: ready got %b want 0", obs_ready);
    end
    idle(); writeback(3'd5, 8'h99); cycle();
  endtask

  task automatic test_async_reset();
    idle(); issue(3'd4, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00); cycle();
    idle();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    n_cmp++;
    if ({out_valid, a, b, op, rd} !== 23'h0) begin
      n_err++;
      $display("FAIL async_reset: got v=%0b a=%h b=%h op=%h rd=%h, want all 0",
               out_valid, a, b, op, rd);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    idle(); issue(3'd0, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00); cycle();
    n_cmp++;
    if ({out_valid, a, b} !== {1'b1, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL after_reset_r1: got v=%0b a=%h b=%h, want 1 00 00", out_valid, a, b);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_op      = 3'($urandom);
      in_rd      = 3'($urandom);
      in_rs1     = 3'($urandom);
      in_rs2     = 3'($urandom);
      in_use_imm = $urandom_range(0, 1) == 1;
      in_imm     = 8'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_en      = $urandom_range(0, 1) == 1;
      wb_rd      = 3'($urandom);
      wb_v       = 8'($urandom);
      cycle();
      n_cmp++;
      if (obs_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: got %b want %b", k, obs_ready, exp_ready);
      end
      n_cmp++;
      if ({out_valid, a, b, op, rd} !== {m_valid, m_a, m_b, m_op, m_rd}) begin
        n_err++;
        $display("FAIL rand_bundle[%0d]: got %0b %h %h %h %h want %0b %h %h %h %h",
                 k, out_valid, a, b, op, rd, m_valid, m_a, m_b, m_op, m_rd);
      end
    end
    idle(); cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm_r0();
    test_stall_bypass();
    test_backpressure();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
